multicycle_ctrl: RTL and testbench

Multi-cycle main control unit for the RV32 core. It fetches an instruction through a request/acknowledge handshake and latches it in an internal instruction register. It then sequences FETCH/DECODE/EXEC/MEM/WB and drives the ALUOp/funct3/funct7/ALUSrc interface consumed by the ALU-control/ALU stage. It also drives the register-file, data-memory and PC strobes, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/main_decoder.sv | 29 ++
 rtl/multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32 control slice:
// opcode constants, ALUOp encodings and the main FSM state type.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

endpackage

// File: rtl/main_decoder.sv
// Main opcode decoder: classifies IR[6:0] into one of the supported
// instruction classes, or flags it as illegal.
// Ports:
//   opcode     in  IR[6:0]
//   is_rtype   out add/sub/and/or
//   is_load    out lw
//   is_store   out sw
//   is_branch  out beq
//   illegal    out none of the above
module main_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    illegal   = !(is_rtype || is_load || is_store || is_branch);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control unit for the RV32 core.
// Fetches through a req/ack handshake into an instruction register, then
// sequences FETCH/DECODE/EXEC/MEM/WB, drives the ALU-control interface and
// the register-file / data-memory / PC strobes, and counts retirements.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/ack/rdata    instruction fetch handshake
//   dmem_req/we/ack       data access handshake (we=1 store)
//   alu_zero              ALU zero flag, steers beq
//   ALUOp/funct3/funct7/ALUSrc   ALU-control interface
//   reg_write/mem_to_reg  register-file write strobe / writeback source
//   pc_write/pc_src       PC update strobe / branch target select
//   ir                    latched instruction
//   illegal               sticky unsupported-opcode trap
//   instret               retired-instruction counter (wraps)
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            alu_zero,
  output logic [1:0]      ALUOp,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            ALUSrc,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            pc_write,
  output logic            pc_src,
  output logic [XLEN-1:0] ir,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            retire;

  logic dec_rtype, dec_load, dec_store, dec_branch, dec_illegal;

  main_decoder u_main_decoder (
    .opcode    (ir_q[6:0]),
    .is_rtype  (dec_rtype),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  // State register; reset wins over any retire on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic; acks are only looked at in FETCH and MEM.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = dec_illegal ? TRAP : EXEC;
      EXEC: begin
        if (dec_rtype) begin
          state_d = WB;
        end else if (dec_load || dec_store) begin
          state_d = MEM;
        end else if (dec_branch) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = TRAP;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          if (dec_store) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    instret_d = instret_q + {{(XLEN-1){1'b0}}, retire};
  end

  // Moore outputs; gated by rst_n so pending requests drop as soon as
  // reset is asserted. pc_src in beq EXEC is the only Mealy term.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ALUOp      = ALUOP_MEM;
    ALUSrc     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: imem_req = 1'b1;
        EXEC: begin
          if (dec_rtype) begin
            ALUOp = ALUOP_R;
          end else if (dec_load || dec_store) begin
            ALUOp  = ALUOP_MEM;
            ALUSrc = 1'b1;
          end else if (dec_branch) begin
            ALUOp    = ALUOP_BR;
            pc_write = 1'b1;
            pc_src   = alu_zero;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_store;
          ALUSrc   = 1'b1;
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = dec_load;
          pc_write   = 1'b1;
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[30];
  assign ir      = ir_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        alu_zero;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        funct7, ALUSrc, reg_write, mem_to_reg, pc_write, pc_src;
  logic [31:0] ir;
  logic        illegal;
  logic [31:0] instret;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] model_cnt;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
    .ALUSrc(ALUSrc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_write(pc_write), .pc_src(pc_src), .ir(ir), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // One scheduled cycle: expected strobes, whether pc_src follows alu_zero,
  // which handshake phase the cycle belongs to and the ack to drive.
  typedef struct packed {
    logic [10:0] v;
    logic        pcf;
    logic        fph;
    logic        mph;
    logic        ack;
    logic        cir;
  } step_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {imem_req,dmem_req,dmem_we,ALUOp,ALUSrc,reg_write,mem_to_reg,pc_write,pc_src,illegal}
  function automatic logic [10:0] outs();
    return {imem_req, dmem_req, dmem_we, ALUOp, ALUSrc, reg_write,
            mem_to_reg, pc_write, pc_src, illegal};
  endfunction

  function automatic logic [10:0] ev(input logic ireq, input logic dreq, input logic we,
                                     input logic [1:0] aop, input logic asrc, input logic rw,
                                     input logic m2r, input logic pcw, input logic ill);
    return {ireq, dreq, we, aop, asrc, rw, m2r, pcw, 1'b0, ill};
  endfunction

  function automatic step_t mk(input logic [10:0] v, input logic pcf, input logic fph,
                               input logic mph, input logic ack, input logic cir);
    step_t s;
    s.v = v; s.pcf = pcf; s.fph = fph; s.mph = mph; s.ack = ack; s.cir = cir;
    return s;
  endfunction

  // Expects the DUT to be in its first FETCH cycle at the next negedge.
  // az_mode: 0/1 fixed alu_zero, 2 random per cycle. n_trap: TRAP cycles observed.
  task automatic run_instr(input string name, input logic [31:0] instr, input int unsigned wf,
                           input int unsigned wd, input int az_mode, input int unsigned n_trap);
    step_t       tl[$];
    logic [6:0]  op;
    logic        is_r, is_lw, is_sw, is_beq, legal, az;
    logic [10:0] expv;
    op     = instr[6:0];
    is_r   = (op == 7'b0110011);
    is_lw  = (op == 7'b0000011);
    is_sw  = (op == 7'b0100011);
    is_beq = (op == 7'b1100011);
    legal  = is_r | is_lw | is_sw | is_beq;
    for (int unsigned i = 0; i <= wf; i++)
      tl.push_back(mk(ev(1,0,0,2'b00,0,0,0,0,0), 0, 1, 0, (i == wf), 0));
    tl.push_back(mk(ev(0,0,0,2'b00,0,0,0,0,0), 0, 0, 0, 0, 1));
    if (!legal) begin
      for (int unsigned i = 0; i < n_trap; i++)
        tl.push_back(mk(ev(0,0,0,2'b00,0,0,0,0,1), 0, 0, 0, 0, 1));
    end else if (is_beq) begin
      tl.push_back(mk(ev(0,0,0,2'b01,0,0,0,1,0), 1, 0, 0, 0, 1));
    end else begin
      if (is_r) tl.push_back(mk(ev(0,0,0,2'b10,0,0,0,0,0), 0, 0, 0, 0, 1));
      else      tl.push_back(mk(ev(0,0,0,2'b00,1,0,0,0,0), 0, 0, 0, 0, 1));
      if (is_lw || is_sw)
        for (int unsigned i = 0; i <= wd; i++)
          tl.push_back(mk(ev(0,1,is_sw,2'b00,1,0,0,0,0), 0, 0, 1, (i == wd), 1));
      if (!is_sw) tl.push_back(mk(ev(0,0,0,2'b00,0,1,is_lw,1,0), 0, 0, 0, 0, 1));
    end
    foreach (tl[k]) begin
      @(negedge clk);
      imem_ack   = tl[k].fph ? tl[k].ack : 1'($urandom_range(0, 1));
      imem_rdata = tl[k].fph ? instr : $urandom();
      dmem_ack   = tl[k].mph ? tl[k].ack : 1'($urandom_range(0, 1));
      az = (az_mode == 2) ? 1'($urandom_range(0, 1)) : az_mode[0];
      alu_zero = az;
      #1;
      expv = tl[k].v;
      expv[1] = tl[k].pcf & az;
      check($sformatf("%s c%0d strobes", name, k + 1), {21'd0, outs()}, {21'd0, expv});
      if (k == 0) check($sformatf("%s instret", name), instret, model_cnt);
      if (tl[k].cir) begin
        check($sformatf("%s c%0d ir", name, k + 1), ir, instr);
        check($sformatf("%s c%0d funct", name, k + 1), {28'd0, funct7, funct3},
              {28'd0, instr[30], instr[14:12]});
      end
    end
    if (legal) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) begin
      #1;
      check("reset strobes", {21'd0, outs()}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("reset ir", ir, 32'd0);
    check("reset instret", instret, 32'd0);
    model_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] w;
    w = $urandom();
    case (cls)
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0000011;
      2: w[6:0] = 7'b0100011;
      3: w[6:0] = 7'b1100011;
      default: begin
        w[6:0] = 7'b1111111;
        while (w[6:0] == 7'b0110011 || w[6:0] == 7'b0000011 ||
               w[6:0] == 7'b0100011 || w[6:0] == 7'b1100011)
          w[6:0] = 7'($urandom());
      end
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    imem_rdata = '0; model_cnt = '0;
    do_reset(2);

    run_instr("add",    32'h002081B3, 0, 0, 2, 0);
    run_instr("lw",     32'h0040A183, 0, 2, 2, 0);
    run_instr("sw",     32'h0030A223, 0, 0, 2, 0);
    run_instr("beq_z1", 32'h00208463, 0, 0, 1, 0);
    run_instr("beq_z0", 32'h00208463, 0, 0, 0, 0);
    run_instr("add_w",  32'h402081B3, 3, 0, 2, 0);
    run_instr("chkcnt", 32'h002081B3, 0, 0, 2, 0);

    run_instr("trap", 32'h0000007F, 0, 0, 2, 6);
    @(negedge clk);
    #1 check("trap sticky", {31'd0, illegal}, 32'd1);
    do_reset(1);
    run_instr("post_trap", 32'h002081B3, 0, 0, 2, 0);

    // Counter wrap: preload all-ones while idling in FETCH.
    @(negedge clk);
    imem_ack = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    @(negedge clk);
    #1 check("preload", instret, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    run_instr("wrap", 32'h002081B3, 0, 0, 2, 0);
    run_instr("after_wrap", 32'h0030A223, 0, 0, 2, 0);

    for (int n = 0; n < 40; n++) begin
      int cls;
      cls = (n % 9 == 8) ? 4 : int'($urandom_range(0, 3));
      run_instr($sformatf("rnd%0d", n), rand_instr(cls), $urandom_range(0, 3),
                $urandom_range(0, 3), 2, 3);
      if (cls == 4) do_reset(1);
    end

    // Reset landing on a completing sw in MEM: no retire, request drops.
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0030A223; dmem_ack = 1'b0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("mem req", {30'd0, dmem_req, dmem_we}, 32'd3);
    @(negedge clk);
    dmem_ack = 1'b1; rst_n = 1'b0;
    #1 check("mem rst drop", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1 check("mem rst req", {30'd0, dmem_req, reg_write}, 32'd0);
    check("mem rst instret", instret, 32'd0);
    model_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr("post_mrst", 32'h002081B3, 0, 0, 2, 0);
    run_instr("post_mrst2", 32'h00208463, 1, 0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
